// File: rtl/hazard_defs_pkg.sv
// ---------------------------------------------------------------------------
// hazard_defs
// Shared definitions for the D-stage hazard scoreboard. It provides:
//   - the forward-select encodings driven on fwd_rs / fwd_rt
//   - the Tnew encodings that the decoder presents on tnew_d
//   - the bit positions of each Tuse flag inside tuse_d
//   - the scoreboard stage record and the saturating Tnew decrement
// Optional feature macro used by the importing files: HAZARD_MD_EN
// ---------------------------------------------------------------------------
package hazard_defs;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // tuse_d = {rs0, rs1, rt0, rt1, rt2}
    localparam int TUSE_RS0 = 4;
    localparam int TUSE_RS1 = 3;
    localparam int TUSE_RT0 = 2;
    localparam int TUSE_RT1 = 1;
    localparam int TUSE_RT2 = 0;

    // Wide enough to hold the longest (divide) busy period.
    localparam int MD_CNT_W = 4;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } stage_t;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// ---------------------------------------------------------------------------
// md_busy_timer
// HI/LO multiply/divide busy timer. Whenever load_i is high on a clock edge,
// the counter takes load_val_i. Otherwise it counts down and stops at zero.
// busy_o is high while the count is non-zero. A pipeline flush does not reach
// this block, so the unit always runs to completion. The block is only
// instantiated when HAZARD_MD_EN is defined.
// Ports:
//   clk        in   pipeline clock
//   rst_n      in   asynchronous active-low reset
//   load_val_i in   busy period to load (MD_CNT_W bits)
//   load_i     in   load strobe
//   busy_o     out  counter non-zero
// ---------------------------------------------------------------------------
module md_busy_timer
    import hazard_defs::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MD_CNT_W-1:0] load_val_i,
    input  logic                load_i,
    output logic                busy_o
);

    logic [MD_CNT_W-1:0] cnt_q;
    logic [MD_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// D-stage hazard controller for the 5-stage MIPS pipeline. A shift-register
// scoreboard tracks the destination register and the remaining Tnew of the
// instructions in E, M and W. W always has a Tnew of 0. From this state and
// the Tuse flags of the instruction in D, the block produces the D-stage
// stall and the rs/rt forward selects.
// Optional feature: HAZARD_MD_EN adds the HI/LO busy timer, the md stall and
// md_busy. When the macro is undefined, md_op_d, md_div_d and md_use_d are
// ignored and md_busy is tied to 0.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   tuse_d[4:0]        {rs0,rs1,rt0,rt1,rt2} Tuse flags of the D instruction
//   rs_d, rt_d         D instruction source register fields
//   dst_d, tnew_d      D instruction destination (0 = none) and Tnew
//   md_op_d, md_div_d  D instruction is mult/div, and is a divide
//   md_use_d           D instruction touches HI/LO
//   flush              exception/ERET flush of E/M/W
//   stall              freeze PC/D and inject a bubble into E
//   fwd_rs, fwd_rt     0 regfile, 1 E, 2 M, 3 W
//   md_busy            HI/LO unit busy
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_defs::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] tuse_d,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] dst_d,
    input  logic [1:0] tnew_d,
    input  logic       md_op_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       md_busy
);

    stage_t     e_q, e_d;
    stage_t     m_q, m_d;
    logic [4:0] w_dst_q, w_dst_d;

    logic       rs_used, rt_used;
    logic [1:0] rs_tuse, rt_tuse;
    logic       rs_stall, rt_stall, md_stall;

    // Only the youngest matching stage is considered. Once E matches, the
    // older M entry is irrelevant because it holds a stale value.
    function automatic logic operand_stall(input logic       used,
                                           input logic [1:0] tuse,
                                           input logic [4:0] r,
                                           input stage_t     e,
                                           input stage_t     m);
        logic s;
        s = 1'b0;
        if (used && (r != 5'd0)) begin
            if (r == e.dst) begin
                s = (e.tnew > tuse);
            end else if (r == m.dst) begin
                s = (m.tnew > tuse);
            end
        end
        return s;
    endfunction

    // Any producer that is not yet ready selects the regfile. The select
    // never falls back to an older stage, which would give stale data.
    function automatic logic [1:0] fwd_select(input logic [4:0] r,
                                              input stage_t     e,
                                              input stage_t     m,
                                              input logic [4:0] w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (r != 5'd0) begin
            if (r == e.dst) begin
                sel = (e.tnew == 2'd0) ? FWD_E : FWD_RF;
            end else if (r == m.dst) begin
                sel = (m.tnew == 2'd0) ? FWD_M : FWD_RF;
            end else if (r == w) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    always_comb begin
        rs_used  = tuse_d[TUSE_RS0] | tuse_d[TUSE_RS1];
        rs_tuse  = tuse_d[TUSE_RS0] ? 2'd0 : 2'd1;
        rt_used  = tuse_d[TUSE_RT0] | tuse_d[TUSE_RT1] | tuse_d[TUSE_RT2];
        rt_tuse  = tuse_d[TUSE_RT0] ? 2'd0 : (tuse_d[TUSE_RT1] ? 2'd1 : 2'd2);
        rs_stall = operand_stall(rs_used, rs_tuse, rs_d, e_q, m_q);
        rt_stall = operand_stall(rt_used, rt_tuse, rt_d, e_q, m_q);
        fwd_rs   = fwd_select(rs_d, e_q, m_q, w_dst_q);
        fwd_rt   = fwd_select(rt_d, e_q, m_q, w_dst_q);
    end

`ifdef HAZARD_MD_EN
    logic                md_load;
    logic [MD_CNT_W-1:0] md_load_val;

    // A stalled or flushed mult/div has not really entered E, so it must
    // not start the timer.
    assign md_load     = md_op_d & ~stall & ~flush;
    assign md_load_val = md_div_d ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);

    md_busy_timer u_md_busy_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_val_i (md_load_val),
        .load_i     (md_load),
        .busy_o     (md_busy)
    );

    assign md_stall = md_use_d & md_busy;
`else
    logic unused_md;
    assign unused_md = ^{md_op_d, md_div_d, md_use_d, (MULT_CYC != 0), (DIV_CYC != 0)};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

    assign stall = rs_stall | rt_stall | md_stall;

    // A flush takes priority over a stall. A stall keeps D frozen, so M and
    // W still advance while E takes a bubble.
    always_comb begin
        e_d     = e_q;
        m_d     = m_q;
        w_dst_d = w_dst_q;
        if (flush) begin
            e_d     = '0;
            m_d     = '0;
            w_dst_d = '0;
        end else if (stall) begin
            e_d      = '0;
            m_d.dst  = e_q.dst;
            m_d.tnew = sat_dec(e_q.tnew);
            w_dst_d  = m_q.dst;
        end else begin
            e_d.dst  = dst_d;
            e_d.tnew = tnew_d;
            m_d.dst  = e_q.dst;
            m_d.tnew = sat_dec(e_q.tnew);
            w_dst_d  = m_q.dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q     <= '0;
            m_q     <= '0;
            w_dst_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_dst_q <= w_dst_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed vectors for hazard_scoreboard. Each vector is driven just after a
// rising edge, and its hand-computed expectation is queued at the same time.
// A separate monitor pops the queue on every falling edge and compares the
// expectation with the combinational outputs.
// Follows HAZARD_MD_EN for the md-related expectations.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_defs::*;

`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] tuse_d, rs_d, rt_d, dst_d;
    logic [1:0] tnew_d;
    logic       md_op_d, md_div_d, md_use_d, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs, fwd_rt;

    logic [5:0] expQ[$];
    string      nameQ[$];
    int         vecCount  = 0;
    int         missCount = 0;

    hazard_scoreboard #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tuse_d   (tuse_d),
        .rs_d     (rs_d),
        .rt_d     (rt_d),
        .dst_d    (dst_d),
        .tnew_d   (tnew_d),
        .md_op_d  (md_op_d),
        .md_div_d (md_div_d),
        .md_use_d (md_use_d),
        .flush    (flush),
        .stall    (stall),
        .fwd_rs   (fwd_rs),
        .fwd_rt   (fwd_rt),
        .md_busy  (md_busy)
    );

    always #5 clk = ~clk;

    // Drive one D-stage cycle and queue the outputs it should produce.
    task automatic applyStimulus(input string      name,
                                 input logic       rstN,
                                 input logic [4:0] tuse,
                                 input logic [4:0] rs,
                                 input logic [4:0] rt,
                                 input logic [4:0] dst,
                                 input logic [1:0] tnew,
                                 input logic       mdOp,
                                 input logic       mdDiv,
                                 input logic       mdUse,
                                 input logic       fl,
                                 input logic       eStall,
                                 input logic [1:0] eRs,
                                 input logic [1:0] eRt,
                                 input logic       eBusy);
        @(posedge clk);
        #1;
        rst_n    = rstN;
        tuse_d   = tuse;
        rs_d     = rs;
        rt_d     = rt;
        dst_d    = dst;
        tnew_d   = tnew;
        md_op_d  = mdOp;
        md_div_d = mdDiv;
        md_use_d = mdUse;
        flush    = fl;
        expQ.push_back({eStall, eRs, eRt, eBusy});
        nameQ.push_back(name);
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    task automatic checkOutput(input logic [5:0] exp, input string name);
        logic [5:0] got;
        got = {stall, fwd_rs, fwd_rt, md_busy};
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got stall=%0b fwd_rs=%0d fwd_rt=%0d md_busy=%0b, expected stall=%0b fwd_rs=%0d fwd_rt=%0d md_busy=%0b",
                     name, got[5], got[4:3], got[2:1], got[0], exp[5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front(), nameQ.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; tuse_d = '0; rs_d = '0; rt_d = '0; dst_d = '0; tnew_d = '0;
        md_op_d = 1'b0; md_div_d = 1'b0; md_use_d = 1'b0; flush = 1'b0;

        //            name              rstN tuse      rs  rt  dst tnew       op div use fl  stall rs     rt     busy
        applyStimulus("reset_state",    0, 5'b00000, 0,  0,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("reset_release",  1, 5'b00000, 0,  0,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);

        // load-use: lw $1, then addu rs=$1 (Tuse 1)
        applyStimulus("lw1_issue",      1, 5'b00000, 0,  0,  1,  TNEW_LOAD, 0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("lw1_use_stall",  1, 5'b01000, 1,  0,  5,  TNEW_ALU,  0, 0, 0, 0,  1, FWD_RF, FWD_RF, 0);
        applyStimulus("lw1_use_go",     1, 5'b01000, 1,  0,  5,  TNEW_ALU,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("fwd_w_rs1",      1, 5'b00000, 1,  5,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_W,  FWD_RF, 0);
        applyStimulus("fwd_m_rt5",      1, 5'b00000, 0,  5,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_RF, FWD_M,  0);

        // addu $2 then beq $2,$2 (Tuse 0); jal then jr $31
        applyStimulus("addu2_issue",    1, 5'b00000, 0,  0,  2,  TNEW_ALU,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("beq_stall",      1, 5'b10100, 2,  2,  0,  TNEW_JAL,  0, 0, 0, 0,  1, FWD_RF, FWD_RF, 0);
        applyStimulus("beq_fwd_m",      1, 5'b10100, 2,  2,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_M,  FWD_M,  0);
        applyStimulus("jal_issue",      1, 5'b00000, 0,  0,  31, TNEW_JAL,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("jr_fwd_e",       1, 5'b10000, 31, 0,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_E,  FWD_RF, 0);

        // lw $3 then sw rt=$3 (Tuse 2); $0 never hazards
        applyStimulus("lw3_issue",      1, 5'b00000, 0,  0,  3,  TNEW_LOAD, 0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("sw_rt2_nostall", 1, 5'b00001, 31, 3,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_W,  FWD_RF, 0);
        applyStimulus("wr_r0_issue",    1, 5'b01000, 0,  3,  0,  TNEW_ALU,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("rd_r0",          1, 5'b10100, 0,  0,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);

        // flush clears the scoreboard and wins over a simultaneous stall
        applyStimulus("lw4_issue",      1, 5'b00000, 0,  0,  4,  TNEW_LOAD, 0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("flush_pulse",    1, 5'b00000, 4,  0,  0,  TNEW_JAL,  0, 0, 0, 1,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("after_flush",    1, 5'b01000, 4,  0,  6,  TNEW_ALU,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("stall_and_flush",1, 5'b10000, 6,  0,  0,  TNEW_JAL,  0, 0, 0, 1,  1, FWD_RF, FWD_RF, 0);
        applyStimulus("after_sf",       1, 5'b10000, 6,  0,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);

        // mult then mflo: busy/stall for 5 cycles when the timer is built
        applyStimulus("mult_issue",     1, 5'b00000, 0,  0,  0,  TNEW_JAL,  1, 0, 1, 0,  0, FWD_RF, FWD_RF, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus("mult_mflo", 1, 5'b00000, 0, 0, 7, TNEW_LOAD, 0, 0, 1, 0,
                          MD_EN && (k < 5), FWD_RF, FWD_RF, MD_EN && (k < 5));
        end

        // div then mflo: 10 cycles; flush mid-way does not clear the timer,
        // and a stalled mult does not reload it
        applyStimulus("div_issue",      1, 5'b00000, 0,  0,  0,  TNEW_JAL,  1, 1, 1, 0,  0, FWD_RF, FWD_RF, 0);
        for (int k = 0; k < 11; k++) begin
            applyStimulus("div_mflo", 1, 5'b00000, 0, 0, 7, TNEW_LOAD, (k == 5), 1'b0, 1, (k == 3),
                          MD_EN && (k < 10), FWD_RF, FWD_RF, MD_EN && (k < 10));
        end

        // async reset in the middle of a stall
        applyStimulus("pre_rst_a",      1, 5'b00000, 0,  0,  9,  TNEW_ALU,  1, 0, 1, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("pre_rst_b",      1, 5'b00000, 0,  0,  8,  TNEW_LOAD, 0, 0, 0, 0,  0, FWD_RF, FWD_RF, MD_EN);
        applyStimulus("pre_rst_stall",  1, 5'b01000, 8,  9,  10, TNEW_ALU,  0, 0, 1, 0,  1, FWD_RF, FWD_M,  MD_EN);
        applyStimulus("async_reset",    0, 5'b01000, 8,  9,  10, TNEW_ALU,  0, 0, 1, 0,  0, FWD_RF, FWD_RF, 0);
        applyStimulus("post_reset",     1, 5'b00000, 0,  0,  0,  TNEW_JAL,  0, 0, 0, 0,  0, FWD_RF, FWD_RF, 0);

        repeat (3) @(posedge clk);
        if (expQ.size() > 0) begin
            missCount++;
            $display("[TB] FAIL drain: got %0d unchecked vectors, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
